// File: rtl/tmr_mem_pkg.sv
// Shared types and helpers for the triple-redundant scrubbed SRAM.
// ST_INJ is only reachable when TMR_FAULT_INJ_EN is defined.
package tmr_mem_pkg;

    localparam int NUM_COPIES = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WB       = 3'd2,
        ST_SCRUB_RD = 3'd3,
        ST_SCRUB_WB = 3'd4,
        ST_INJ      = 3'd5
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 voter with per-copy disagreement mask and
// an uncorrectable flag raised when all three copies pairwise differ.
module tmr_vote
    import tmr_mem_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]     c0,
    input  logic [DATA_W-1:0]     c1,
    input  logic [DATA_W-1:0]     c2,
    output logic [DATA_W-1:0]     voted,
    output logic [NUM_COPIES-1:0] mism,
    output logic                  uncorr
);

    // Per-bit majority across the three copies
    always_comb begin
        voted = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            voted[i] = maj3(c0[i], c1[i], c2[i]);
        end
    end

    assign mism   = {(c2 != voted), (c1 != voted), (c0 != voted)};
    assign uncorr = (c0 != c1) && (c1 != c2) && (c0 != c2);

endmodule

// File: rtl/tmr_sram_scrub.sv
// Triple-redundant single-port SRAM with voted reads, write-back repair and a
// background scrubber. Define TMR_FAULT_INJ_EN to add the fault-injection port.
module tmr_sram_scrub
    import tmr_mem_pkg::*;
#(
    parameter  int DATA_W       = 8,
    parameter  int DEPTH        = 256,
    parameter  int SCRUB_PERIOD = 1024,
    parameter  int CNT_W        = 16,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_corrected,
    input  logic              scrub_en,
    output logic [CNT_W-1:0]  corr_count,
    output logic              multi_err
`ifdef TMR_FAULT_INJ_EN
    ,
    input  logic              inj_valid,
    input  logic [1:0]        inj_copy,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [DATA_W-1:0] inj_mask
`endif
);

    localparam int TIMER_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(SCRUB_PERIOD - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    state_e                state_r;
    logic                  rst_done_r;
    logic [TIMER_W-1:0]    timer_r;
    logic [ADDR_W-1:0]     scrub_addr_r;
    logic [ADDR_W-1:0]     op_addr_r;
    logic [DATA_W-1:0]     voted_r;
    logic [NUM_COPIES-1:0] mask_r;

    logic [ADDR_W-1:0]     rd_addr_s;
    logic [ADDR_W-1:0]     mem_addr_s;
    logic [DATA_W-1:0]     mem_wdata_s;
    logic [NUM_COPIES-1:0] mem_we_s;
    logic [DATA_W-1:0]     copy_rd_s [NUM_COPIES];
    logic [DATA_W-1:0]     voted_s;
    logic [NUM_COPIES-1:0] mism_s;
    logic                  uncorr_s;
    logic                  scrub_go_s;
    logic                  req_accept_s;
    logic                  rd_accept_s;
    logic                  wr_accept_s;
    logic                  capture_s;

    // A scrub only starts when no request is waiting, so user traffic always wins
    assign scrub_go_s   = rst_done_r && scrub_en && (timer_r == TIMER_MAX) && !req_valid;
    assign req_ready    = rst_done_r && (state_r == ST_IDLE) && !scrub_go_s;
    assign req_accept_s = req_valid && req_ready;
    assign rd_accept_s  = req_accept_s && !req_we;
    assign wr_accept_s  = req_accept_s && req_we;
    assign capture_s    = (state_r == ST_IDLE) && (rd_accept_s || scrub_go_s);

`ifdef TMR_FAULT_INJ_EN
    logic              inj_go_s;
    logic [DATA_W-1:0] inj_rd_s;
    logic [1:0]        inj_copy_r;
    logic [DATA_W-1:0] inj_data_r;

    assign inj_go_s = rst_done_r && (state_r == ST_IDLE) && inj_valid &&
                      (inj_copy != 2'd3) && !req_valid && !scrub_go_s;

    // Read address and raw copy selection for injection read-modify-write
    always_comb begin
        if (scrub_go_s) begin
            rd_addr_s = scrub_addr_r;
        end else if (inj_go_s) begin
            rd_addr_s = inj_addr;
        end else begin
            rd_addr_s = req_addr;
        end
        case (inj_copy)
            2'd0:    inj_rd_s = copy_rd_s[0];
            2'd1:    inj_rd_s = copy_rd_s[1];
            2'd2:    inj_rd_s = copy_rd_s[2];
            default: inj_rd_s = {DATA_W{1'b0}};
        endcase
    end
`else
    assign rd_addr_s = scrub_go_s ? scrub_addr_r : req_addr;
`endif

    for (genvar c = 0; c < NUM_COPIES; c++) begin : g_copy
        logic [DATA_W-1:0] mem [DEPTH];

        // Storage copy: one write port, read at the shared read address
        always_ff @(posedge clk) begin
            if (mem_we_s[c]) begin
                mem[mem_addr_s] <= mem_wdata_s;
            end
        end

        assign copy_rd_s[c] = mem[rd_addr_s];
    end

    tmr_vote #(.DATA_W(DATA_W)) u_vote (
        .c0     (copy_rd_s[0]),
        .c1     (copy_rd_s[1]),
        .c2     (copy_rd_s[2]),
        .voted  (voted_s),
        .mism   (mism_s),
        .uncorr (uncorr_s)
    );

    // Write-port steering: user writes hit all copies, repairs only the disagreeing ones
    always_comb begin
        mem_we_s    = 3'b000;
        mem_addr_s  = op_addr_r;
        mem_wdata_s = voted_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_accept_s) begin
                    mem_we_s    = 3'b111;
                    mem_addr_s  = req_addr;
                    mem_wdata_s = req_wdata;
                end else begin
                    mem_we_s    = 3'b000;
                end
            end
            ST_WB, ST_SCRUB_WB: mem_we_s = mask_r;
`ifdef TMR_FAULT_INJ_EN
            ST_INJ: begin
                mem_wdata_s = inj_data_r;
                case (inj_copy_r)
                    2'd0:    mem_we_s = 3'b001;
                    2'd1:    mem_we_s = 3'b010;
                    2'd2:    mem_we_s = 3'b100;
                    default: mem_we_s = 3'b000;
                endcase
            end
`endif
            default: mem_we_s = 3'b000;
        endcase
    end

    // Main controller: request/scrub sequencing and the registered read response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rst_done_r    <= 1'b0;
            scrub_addr_r  <= {ADDR_W{1'b0}};
            op_addr_r     <= {ADDR_W{1'b0}};
            voted_r       <= {DATA_W{1'b0}};
            mask_r        <= 3'b000;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= {DATA_W{1'b0}};
            rsp_corrected <= 1'b0;
`ifdef TMR_FAULT_INJ_EN
            inj_copy_r    <= 2'd0;
            inj_data_r    <= {DATA_W{1'b0}};
`endif
        end else begin
            rst_done_r    <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_corrected <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rd_accept_s) begin
                        state_r       <= ST_RD;
                        op_addr_r     <= req_addr;
                        voted_r       <= voted_s;
                        mask_r        <= mism_s;
                        rsp_valid     <= 1'b1;
                        rsp_rdata     <= voted_s;
                        rsp_corrected <= |mism_s;
                    end else if (scrub_go_s) begin
                        state_r   <= ST_SCRUB_RD;
                        op_addr_r <= scrub_addr_r;
                        voted_r   <= voted_s;
                        mask_r    <= mism_s;
`ifdef TMR_FAULT_INJ_EN
                    end else if (inj_go_s) begin
                        state_r    <= ST_INJ;
                        op_addr_r  <= inj_addr;
                        inj_copy_r <= inj_copy;
                        inj_data_r <= inj_rd_s ^ inj_mask;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD:       state_r <= (|mask_r) ? ST_WB : ST_IDLE;
                ST_WB:       state_r <= ST_IDLE;
                ST_SCRUB_RD: begin
                    if (|mask_r) begin
                        state_r <= ST_SCRUB_WB;
                    end else begin
                        state_r      <= ST_IDLE;
                        scrub_addr_r <= (scrub_addr_r == ADDR_LAST) ? {ADDR_W{1'b0}}
                                                                    : scrub_addr_r + ADDR_W'(1);
                    end
                end
                ST_SCRUB_WB: begin
                    state_r      <= ST_IDLE;
                    scrub_addr_r <= (scrub_addr_r == ADDR_LAST) ? {ADDR_W{1'b0}}
                                                                : scrub_addr_r + ADDR_W'(1);
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Correction statistics, updated when a word is read for a request or a scrub
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count <= {CNT_W{1'b0}};
            multi_err  <= 1'b0;
        end else if (capture_s) begin
            if ((|mism_s) && (corr_count != CNT_MAX)) begin
                corr_count <= corr_count + CNT_W'(1);
            end else begin
                corr_count <= corr_count;
            end
            multi_err <= multi_err | uncorr_s;
        end else begin
            corr_count <= corr_count;
            multi_err  <= multi_err;
        end
    end

    // Idle timer: saturates at the period so a deferred scrub fires once the bus frees
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TIMER_W{1'b0}};
        end else if (!scrub_en) begin
            timer_r <= {TIMER_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (scrub_go_s || req_accept_s) begin
                timer_r <= {TIMER_W{1'b0}};
            end else if (timer_r != TIMER_MAX) begin
                timer_r <= timer_r + TIMER_W'(1);
            end else begin
                timer_r <= timer_r;
            end
        end else begin
            timer_r <= timer_r;
        end
    end

endmodule
